l2_ram_banked_pipe: RTL and testbench
=====================================

# l2_ram_banked_pipe

Parametrised L2 memory subsystem: `NB_BANKS` word-interleaved SRAM banks plus `NB_PRI` contiguous private banks. Each bank has its own TCDM-style slave port and a configurable read latency. Out-of-range accesses return an error response. An optional hardware zeroization sweep clears all banks after reset. It sits behind the SoC L2 crossbar and is the generalised successor of the fixed 4+2 bank, 1-cycle L2 array.

## Interface
Parameters:
- `NB_BANKS`, 4: interleaved banks; power of two, ≥1.
- `BANK_WORDS`, 32768: words per interleaved bank; power of two.
- `NB_PRI`, 2: private banks; ≥0.
- `PRI_WORDS`, 8192: words per private bank; power of two, ≤ `BANK_WORDS`.
- `DATA_WIDTH`, 32: word width; multiple of 8. `BE_W` = `DATA_WIDTH`/8.
- `RD_LATENCY`, 1: request-to-`r_valid` cycles, range 1..3.
- `INTL_BASE`, 32'h1C01_0000: interleaved region byte base.
- `PRI_BASE`, 32'h1C00_0000: private bank 0 base. Bank k base = `PRI_BASE` + k·`PRI_WORDS`·`BE_W`.

Ports (NP = `NB_BANKS`+`NB_PRI`; index 0..`NB_BANKS`-1 = interleaved, the rest private):
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `init_ni` in 1: active-low zeroization request.
- `test_mode_i` in 1: passed to macros; no functional effect.
- `req_i` in [NP]: request.
- `add_i` in [NP][32]: byte address.
- `wen_i` in [NP]: 0 = write, 1 = read.
- `wdata_i` in [NP][DATA_WIDTH]: write data.
- `be_i` in [NP][BE_W]: byte enables.
- `gnt_o` out [NP]: grant.
- `r_valid_o` out [NP]: response valid.
- `r_rdata_o` out [NP][DATA_WIDTH]: read data.
- `r_opc_o` out [NP]: 1 = address error.
- `init_done_o` out 1: memory ready.

## Operation
- **Grant:** `gnt_o[i] = req_i[i] & ready`. `ready` = 1 outside the zeroization sweep. Ports are fully independent; there is no arbitration.
- **Interleaved address:** offset = `add_i` − `INTL_BASE`.
  - Word index = offset[`log2(BANK_WORDS)`+2+`log2(NB_BANKS)`−1 : 2+`log2(NB_BANKS)`].
  - In range iff offset < `NB_BANKS`·`BANK_WORDS`·`BE_W` (unsigned; bases below the region wrap and count as out of range).
- **Private address:** offset = `add_i` − bank base.
  - Word index = offset[`log2(PRI_WORDS)`+1 : 2].
  - In range iff offset < `PRI_WORDS`·`BE_W`.
- **In-range granted access:** macro enabled. Write strobe = ~`wen_i`, masked by `be_i`.
- **Out-of-range granted access:** macro not enabled and memory unmodified. The response has `r_opc_o`=1 and `r_rdata_o`=0.
- **Response:**
  - Every granted request, read or write, produces exactly one `r_valid_o` pulse `RD_LATENCY` cycles later.
  - `r_rdata_o` holds the macro output for reads; it is don't-care for writes.
  - `r_opc_o` is aligned with `r_valid_o`.
- **Pipeline:** each port has a shift register of `RD_LATENCY` valid/err bits and `RD_LATENCY`−1 data stages after the 1-cycle macro. Back-to-back requests are accepted every cycle.

## Timing
- **Reset values:**
  - `r_valid_o` = 0, `r_opc_o` = 0, data stages = 0.
  - `init_done_o` = 0 with zeroization compiled in, else 1.
  - `gnt_o` is combinational.
- **Latency:** request at cycle T, response at T+`RD_LATENCY`. Throughput is one request per port per cycle.
- **Reset mid-operation:** in-flight responses are discarded. No `r_valid_o` appears after `rst_ni` is released until a new grant.
- **Read-after-write, same word:** a write at T followed by a read at T+1 returns the new data, honouring `be_i`.
- **Simultaneous requests on all NP ports:** all are granted in the same cycle.

## Configuration
`L2_MEM_ZEROIZE_EN`
- **Defined:** FSM with states INIT and READY. After reset the FSM enters INIT with counter = 0.
  - INIT behaviour:
    - All `gnt_o` = 0.
    - Every bank writes 0 with all byte enables to word `counter`.
    - Private banks skip writes once `counter` ≥ `PRI_WORDS`.
  - INIT → READY when `counter` = `BANK_WORDS`−1. `init_done_o` rises in the first READY cycle, so the sweep takes `BANK_WORDS` cycles.
  - `init_ni`=0 in any state forces INIT with counter = 0. The counter holds at 0 while `init_ni`=0.
  - Responses already in the pipeline complete normally.
- **Undefined:** no FSM. `ready` = 1, `init_done_o` = 1, `init_ni` ignored, and memory content after reset is undefined.

## Test plan
- NB_BANKS=4, RD_LATENCY=1: write 32'hDEAD_BEEF to 0x1C01_0004 on port 1, read it back → `r_valid_o[1]` at T+1 with 32'hDEAD_BEEF and `r_opc_o`=0.
- RD_LATENCY=3, reads on port 0 every cycle for 8 cycles → 8 consecutive `r_valid_o` pulses starting at T+3, data in request order.
- Read of 0x1C00_0000 + 8192·4 on private port 0 (out of range) → `r_valid_o` at T+`RD_LATENCY`, `r_opc_o`=1, rdata 0; neighbouring bank 1 contents unchanged.
- Write with `be_i`=4'b0010, data 32'h0000_AB00, over 32'h1122_3344 → read returns 32'h1122_AB44.
- `L2_MEM_ZEROIZE_EN`, BANK_WORDS=64: after reset `gnt_o`=0 for 64 cycles, then `init_done_o`=1; any read returns 0.
- `L2_MEM_ZEROIZE_EN`: pulse `init_ni` low for 2 cycles in READY → `init_done_o` falls next cycle and rises again after 64 cycles; prior data now reads 0.

Source files
------------

// File: rtl/l2_ram_banked_pipe_if.sv
// Bank-port bundle for l2_ram_banked_pipe: one TCDM-style slave port per bank.
// Signal suffixes are from the memory's point of view.
interface l2_ram_banked_pipe_if #(
    parameter int unsigned NP         = 6,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [NP-1:0]                 req_i;
    logic [NP-1:0][31:0]           add_i;
    logic [NP-1:0]                 wen_i;
    logic [NP-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NP-1:0][BE_W-1:0]       be_i;
    logic [NP-1:0]                 gnt_o;
    logic [NP-1:0]                 r_valid_o;
    logic [NP-1:0][DATA_WIDTH-1:0] r_rdata_o;
    logic [NP-1:0]                 r_opc_o;

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o
    );
endinterface

// File: rtl/l2_ram_banked_pipe.sv
// Banked L2 memory: NB_BANKS word-interleaved banks plus NB_PRI contiguous private
// banks, each with its own port and a RD_LATENCY-deep response pipeline.
// Out-of-range accesses answer with r_opc_o=1 and zero data without touching memory.
// Optional feature macro: L2_MEM_ZEROIZE_EN adds a post-reset/init_ni zeroization sweep.
module l2_ram_banked_pipe #(
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned BANK_WORDS = 32768,
    parameter int unsigned NB_PRI     = 2,
    parameter int unsigned PRI_WORDS  = 8192,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [31:0] INTL_BASE  = 32'h1C01_0000,
    parameter logic [31:0] PRI_BASE   = 32'h1C00_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    init_ni,
    input  logic                    test_mode_i,
    output logic                    init_done_o,
    l2_ram_banked_pipe_if.slave     bus
);
    localparam int unsigned NP       = NB_BANKS + NB_PRI;
    localparam int unsigned BE_W     = DATA_WIDTH / 8;
    localparam int unsigned BankSelW = $clog2(NB_BANKS);
    localparam int unsigned CntW     = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam longint unsigned IntlSize = longint'(NB_BANKS) * BANK_WORDS * BE_W;
    localparam longint unsigned PriSize  = longint'(PRI_WORDS) * BE_W;

    logic            ready;
    logic            zero_wr;
    logic [CntW-1:0] cnt;
    logic            unused_in;

`ifdef L2_MEM_ZEROIZE_EN
    typedef enum logic {StInit, StReady} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Sweep state and word counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep sequencing; init_ni low restarts from word 0 and holds there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                if (!init_ni) begin
                    cnt_d = '0;
                end else if (cnt_q == CntW'(BANK_WORDS - 1)) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                if (!init_ni) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready       = (state_q == StReady);
    assign zero_wr     = (state_q == StInit);
    assign cnt         = cnt_q;
    assign init_done_o = ready;
    assign unused_in   = test_mode_i;
`else
    assign ready       = 1'b1;
    assign zero_wr     = 1'b0;
    assign cnt         = '0;
    assign init_done_o = 1'b1;
    assign unused_in   = ^{test_mode_i, init_ni};
`endif

    logic [NP-1:0]                 gnt_all;
    logic [NP-1:0]                 vld_all;
    logic [NP-1:0]                 opc_all;
    logic [NP-1:0][DATA_WIDTH-1:0] rdata_all;

    assign bus.gnt_o     = gnt_all;
    assign bus.r_valid_o = vld_all;
    assign bus.r_opc_o   = opc_all;
    assign bus.r_rdata_o = rdata_all;

    for (genvar i = 0; i < NP; i++) begin : g_port
        localparam int unsigned Depth = (i < NB_BANKS) ? BANK_WORDS : PRI_WORDS;
        localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

        logic [31:0]           offset;
        logic [IdxW-1:0]       idx;
        logic                  in_range;
        logic                  gnt;
        logic                  me;
        logic                  we;
        logic [IdxW-1:0]       maddr;
        logic [DATA_WIDTH-1:0] mwdata;
        logic [BE_W-1:0]       mbe;
        logic [DATA_WIDTH-1:0] mrdata;
        logic [DATA_WIDTH-1:0] data_out;
        logic [DATA_WIDTH-1:0] mem [Depth];
        logic [RD_LATENCY-1:0] vld_q, err_q;

        if (i < NB_BANKS) begin : g_intl
            // Bank-select bits sit between the byte offset and the word index.
            assign offset   = bus.add_i[i] - INTL_BASE;
            assign idx      = IdxW'(offset >> (2 + BankSelW));
            assign in_range = {32'h0, offset} < IntlSize;
        end else begin : g_pri
            localparam logic [31:0] Base = PRI_BASE + 32'((i - NB_BANKS) * PRI_WORDS * BE_W);
            assign offset   = bus.add_i[i] - Base;
            assign idx      = IdxW'(offset >> 2);
            assign in_range = {32'h0, offset} < PriSize;
        end

        assign gnt        = bus.req_i[i] & ready;
        assign gnt_all[i] = gnt;

        // Macro controls: functional access, or a zero write while sweeping.
        always_comb begin
            me     = gnt & in_range;
            we     = ~bus.wen_i[i];
            maddr  = idx;
            mwdata = bus.wdata_i[i];
            mbe    = bus.be_i[i];
            if (zero_wr) begin
                // Private banks are shorter than the sweep; skip their missing words.
                me     = (32'(cnt) < Depth);
                we     = 1'b1;
                maddr  = cnt[IdxW-1:0];
                mwdata = '0;
                mbe    = '1;
            end
        end

        // Single-port SRAM macro with byte-enabled writes and registered read data.
        always_ff @(posedge clk_i) begin
            if (me) begin
                if (we) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (mbe[b]) mem[maddr][8*b +: 8] <= mwdata[8*b +: 8];
                    end
                end else begin
                    mrdata <= mem[maddr];
                end
            end
        end

        // Response valid/error shift register; reset drops anything in flight.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                err_q <= '0;
            end else begin
                vld_q[0] <= gnt;
                err_q[0] <= gnt & ~in_range;
                for (int s = 1; s < RD_LATENCY; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    err_q[s] <= err_q[s-1];
                end
            end
        end

        if (RD_LATENCY > 1) begin : g_dpipe
            logic [RD_LATENCY-2:0][DATA_WIDTH-1:0] dat_q;

            // Extra read-data stages behind the macro output.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    dat_q <= '0;
                end else begin
                    dat_q[0] <= mrdata;
                    for (int s = 1; s < RD_LATENCY - 1; s++) begin
                        dat_q[s] <= dat_q[s-1];
                    end
                end
            end

            assign data_out = dat_q[RD_LATENCY-2];
        end else begin : g_dnopipe
            assign data_out = mrdata;
        end

        assign vld_all[i]   = vld_q[RD_LATENCY-1];
        assign opc_all[i]   = err_q[RD_LATENCY-1];
        // Errored accesses never enabled the macro, so force zero data.
        assign rdata_all[i] = err_q[RD_LATENCY-1] ? '0 : data_out;
    end
endmodule

// File: tb/tb_l2_ram_banked_pipe.sv
// Self-checking bench for l2_ram_banked_pipe: vector table plus hand sequences,
// responses checked against a per-port scoreboard of expected (cycle, opc, data).
module tb_l2_ram_banked_pipe;
    localparam int unsigned NbBanks   = 4;
    localparam int unsigned BankWords = 64;
    localparam int unsigned NbPri     = 2;
    localparam int unsigned PriWords  = 16;
    localparam int unsigned Lat       = 3;
    localparam int unsigned NP        = NbBanks + NbPri;
    localparam int unsigned NV        = 19;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic init_ni;
    logic test_mode_i;
    logic init_done_o;

    l2_ram_banked_pipe_if #(.NP(NP), .DATA_WIDTH(32)) bus ();

    l2_ram_banked_pipe #(
        .NB_BANKS  (NbBanks),
        .BANK_WORDS(BankWords),
        .NB_PRI    (NbPri),
        .PRI_WORDS (PriWords),
        .DATA_WIDTH(32),
        .RD_LATENCY(Lat),
        .INTL_BASE (32'h1C01_0000),
        .PRI_BASE  (32'h1C00_0000)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .init_ni    (init_ni),
        .test_mode_i(test_mode_i),
        .init_done_o(init_done_o),
        .bus        (bus)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic        opc;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_opc;
        logic [31:0] exp_rdata;
        logic        chk;
    } vec_t;

    exp_t sb [NP][$];
    exp_t mon_e;
    vec_t vt [NV];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic clr();
        bus.req_i   = '0;
        bus.wen_i   = '1;
        bus.add_i   = '0;
        bus.wdata_i = '0;
        bus.be_i    = '0;
    endtask

    task automatic put(input int p, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] b, input logic eo, input logic [31:0] er, input logic ec);
        exp_t e;
        bus.req_i[p]   = 1'b1;
        bus.add_i[p]   = a;
        bus.wen_i[p]   = w;
        bus.wdata_i[p] = d;
        bus.be_i[p]    = b;
        e.due  = cyc + Lat;
        e.opc  = eo;
        e.data = er;
        e.chk  = ec;
        sb[p].push_back(e);
    endtask

    task automatic drain();
        repeat (Lat + 2) @(negedge clk_i);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("drain_port%0d_pending", p), 64'(sb[p].size()), 64'd0);
            sb[p].delete();
        end
    endtask

    // Count posedges until init_done_o rises, with all ports requesting meanwhile.
    task automatic wait_sweep(input string name);
        int n;
        int gnt_seen;
        n = 0;
        gnt_seen = 0;
        bus.req_i = '1;
        while (n < 200) begin
            @(negedge clk_i);
            if (init_done_o) break;
            if (bus.gnt_o != '0) gnt_seen++;
            @(posedge clk_i);
            n++;
        end
        clr();
        check({name, "_cycles"}, 64'(n), 64'(BankWords));
        check({name, "_gnt_during_init"}, 64'(gnt_seen), 64'd0);
    endtask

    // Response monitor: every r_valid_o must match the oldest expectation exactly.
    always @(negedge clk_i) begin
        for (int p = 0; p < NP; p++) begin
            if (bus.r_valid_o[p]) begin
                n_vec++;
                if (sb[p].size() == 0) begin
                    n_err++;
                    $display("FAIL resp_unexpected port %0d: got r_valid at cycle %0d, required none",
                             p, cyc);
                end else begin
                    mon_e = sb[p].pop_front();
                    if (mon_e.due != cyc || bus.r_opc_o[p] !== mon_e.opc ||
                        (mon_e.chk && bus.r_rdata_o[p] !== mon_e.data)) begin
                        n_err++;
                        $display("FAIL resp port %0d: got cycle %0d opc %0b rdata %h, required cycle %0d opc %0b rdata %h",
                                 p, cyc, bus.r_opc_o[p], bus.r_rdata_o[p],
                                 mon_e.due, mon_e.opc, mon_e.data);
                    end
                end
            end else if (sb[p].size() != 0 && sb[p][0].due < cyc) begin
                n_err++;
                $display("FAIL resp_missing port %0d: got no r_valid by cycle %0d, required at %0d",
                         p, cyc, sb[p][0].due);
                mon_e = sb[p].pop_front();
            end
        end
    end

    initial begin
        vt[0]  = '{1, 32'h1C01_0004, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         1'b0};
        vt[1]  = '{1, 32'h1C01_0004, 1'b1, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vt[2]  = '{2, 32'h1C01_0028, 1'b0, 32'h1122_3344, 4'hF, 1'b0, 32'h0,         1'b0};
        vt[3]  = '{2, 32'h1C01_0028, 1'b0, 32'h0000_AB00, 4'h2, 1'b0, 32'h0,         1'b0};
        vt[4]  = '{2, 32'h1C01_0028, 1'b1, 32'h0,         4'hF, 1'b0, 32'h1122_AB44, 1'b1};
        vt[5]  = '{3, 32'h1C01_000C, 1'b0, 32'h0102_0304, 4'hF, 1'b0, 32'h0,         1'b0};
        vt[6]  = '{3, 32'h1C01_000C, 1'b0, 32'h7F00_0000, 4'h8, 1'b0, 32'h0,         1'b0};
        vt[7]  = '{3, 32'h1C01_000C, 1'b1, 32'h0,         4'hF, 1'b0, 32'h7F02_0304, 1'b1};
        vt[8]  = '{4, 32'h1C00_003C, 1'b0, 32'hCAFE_0001, 4'hF, 1'b0, 32'h0,         1'b0};
        vt[9]  = '{5, 32'h1C00_0040, 1'b0, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0,         1'b0};
        vt[10] = '{4, 32'h1C00_0040, 1'b1, 32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
        vt[11] = '{4, 32'h1C00_0040, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b1};
        vt[12] = '{5, 32'h1C00_0040, 1'b1, 32'h0,         4'hF, 1'b0, 32'h55AA_55AA, 1'b1};
        vt[13] = '{4, 32'h1C00_003C, 1'b1, 32'h0,         4'hF, 1'b0, 32'hCAFE_0001, 1'b1};
        vt[14] = '{0, 32'h1C00_FFFC, 1'b1, 32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
        vt[15] = '{0, 32'h1C01_0400, 1'b1, 32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
        vt[16] = '{0, 32'h1C01_03FC, 1'b0, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0,         1'b0};
        vt[17] = '{0, 32'h1C01_03FC, 1'b1, 32'h0,         4'hF, 1'b0, 32'h0BAD_F00D, 1'b1};
        vt[18] = '{5, 32'h1C00_0080, 1'b1, 32'h0,         4'hF, 1'b1, 32'h0,         1'b1};

        rst_ni      = 1'b0;
        init_ni     = 1'b1;
        test_mode_i = 1'b0;
        clr();

        // Reset values.
        repeat (3) @(negedge clk_i);
        check("reset_r_valid", 64'(bus.r_valid_o), 64'd0);
        check("reset_r_opc", 64'(bus.r_opc_o), 64'd0);
        check("reset_r_rdata", 64'(bus.r_rdata_o[0] | bus.r_rdata_o[5]), 64'd0);
`ifdef L2_MEM_ZEROIZE_EN
        check("reset_init_done", 64'(init_done_o), 64'd0);
`else
        check("reset_init_done", 64'(init_done_o), 64'd1);
`endif
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

`ifdef L2_MEM_ZEROIZE_EN
        wait_sweep("sweep_after_reset");
        @(posedge clk_i); #1;
        clr();
        put(1, 32'h1C01_0004, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1);
        put(4, 32'h1C00_003C, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1);
        @(posedge clk_i); #1;
        clr();
        drain();
`endif

        // Vector table, one request per cycle back-to-back.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i); #1;
            clr();
            put(vt[i].port, vt[i].addr, vt[i].wen, vt[i].wdata, vt[i].be,
                vt[i].exp_opc, vt[i].exp_rdata, vt[i].chk);
            @(negedge clk_i);
            check($sformatf("vec%0d_gnt", i), 64'(bus.gnt_o), 64'(1 << vt[i].port));
        end
        @(posedge clk_i); #1;
        clr();
        drain();

        // Streaming: 8 writes then 8 reads every cycle on port 0.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i); #1;
            clr();
            put(0, 32'h1C01_0000 + 32'(16 * (8 + k)), 1'b0, 32'h1000_0000 + 32'(k), 4'hF,
                1'b0, 32'h0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i); #1;
            clr();
            put(0, 32'h1C01_0000 + 32'(16 * (8 + k)), 1'b1, 32'h0, 4'hF,
                1'b0, 32'h1000_0000 + 32'(k), 1'b1);
        end
        @(posedge clk_i); #1;
        clr();
        drain();

        // All ports in the same cycle.
        @(posedge clk_i); #1;
        clr();
        put(0, 32'h1C01_03FC, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 1'b1);
        put(1, 32'h1C01_0004, 1'b1, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1);
        put(2, 32'h1C01_0028, 1'b1, 32'h0, 4'hF, 1'b0, 32'h1122_AB44, 1'b1);
        put(3, 32'h1C01_000C, 1'b1, 32'h0, 4'hF, 1'b0, 32'h7F02_0304, 1'b1);
        put(4, 32'h1C00_003C, 1'b1, 32'h0, 4'hF, 1'b0, 32'hCAFE_0001, 1'b1);
        put(5, 32'h1C00_0040, 1'b1, 32'h0, 4'hF, 1'b0, 32'h55AA_55AA, 1'b1);
        @(negedge clk_i);
        check("all_ports_gnt", 64'(bus.gnt_o), 64'h3F);
        @(posedge clk_i); #1;
        clr();
        drain();

`ifdef L2_MEM_ZEROIZE_EN
        // Re-init via a 2-cycle init_ni pulse while READY.
        @(posedge clk_i); #1;
        init_ni = 1'b0;
        @(posedge clk_i); #1;
        check("reinit_init_done_fall", 64'(init_done_o), 64'd0);
        @(posedge clk_i); #1;
        init_ni = 1'b1;
        wait_sweep("sweep_after_init_ni");
        @(posedge clk_i); #1;
        clr();
        put(1, 32'h1C01_0004, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1);
        put(5, 32'h1C00_0040, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1);
        @(posedge clk_i); #1;
        clr();
        drain();
`endif

        // Reset with reads in flight: responses must be discarded.
        @(posedge clk_i); #1;
        clr();
        put(1, 32'h1C01_0004, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
        @(posedge clk_i); #1;
        clr();
        put(1, 32'h1C01_0004, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
        @(posedge clk_i); #1;
        clr();
        rst_ni = 1'b0;
        for (int p = 0; p < NP; p++) sb[p].delete();
        repeat (2) @(negedge clk_i);
        check("midop_reset_r_valid", 64'(bus.r_valid_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int k = 0; k < Lat + 3; k++) begin
            @(negedge clk_i);
            check($sformatf("no_resp_after_reset_c%0d", k), 64'(bus.r_valid_o), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
